// File: rtl/aes_plat_pkg.sv
// Shared types for the AES platform run sequencer: state encoding, counter width
// and saturating counter arithmetic.
package aes_plat_pkg;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_ERR,
    ST_DONE
  } seq_state_t;

  function automatic cnt_t sat_add32(input cnt_t a, input cnt_t b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Idle-cycle detector: counts enabled cycles since the last clear and pulses
// expire in the cycle the count reaches LIMIT.
module seq_watchdog
  import aes_plat_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam cnt_t LAST = cnt_t'(LIMIT - 1);

  cnt_t r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the cycle that would take the count to LIMIT, so the owner can leave
  // its state exactly LIMIT quiet cycles after the last clear.
  assign expire = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/aes_test_sequencer.sv
// Run-level controller for the AES platform: runs one or two enc/dec phases,
// tallies scoreboard deltas per phase and aborts on stalled progress.
module aes_test_sequencer
  import aes_plat_pkg::*;
#(
  parameter int VECTORS        = 1024,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        both_modes,
  input  logic        enc_first,
  input  logic [31:0] total,
  input  logic [31:0] correct,
  output logic        work,
  output logic        enc,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        phase,
  output logic [31:0] run_total,
  output logic [31:0] run_errors
);

  seq_state_t r_state, w_state_next;
  logic r_both, r_enc, r_phase, r_pass, r_timeout, r_done;
  cnt_t r_base_t, r_base_c, r_total_prev, r_run_total, r_run_errors;
  cnt_t w_dt, w_dc, w_phase_err, w_sum_total, w_sum_err;
  logic w_total_chg, w_active, w_draining, w_wd_expire, w_quiet_expire, w_next_phase;

  assign w_dt         = total - r_base_t;
  assign w_dc         = correct - r_base_c;
  // An inconsistent scoreboard (more matches than results) counts as a clean phase.
  assign w_phase_err  = (w_dc > w_dt) ? '0 : (w_dt - w_dc);
  assign w_sum_total  = sat_add32(r_run_total, w_dt);
  assign w_sum_err    = sat_add32(r_run_errors, w_phase_err);
  assign w_total_chg  = (total != r_total_prev);
  assign w_active     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_draining   = (r_state == ST_DRAIN);
  assign w_next_phase = r_both && !r_phase;

  seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_total_chg || !w_active),
    .enable (w_active),
    .expire (w_wd_expire)
  );

  seq_watchdog #(.LIMIT(SETTLE_CYCLES)) u_quiet_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_total_chg || !w_draining),
    .enable (w_draining),
    .expire (w_quiet_expire)
  );

  always_comb begin
    w_state_next = r_state;
    work         = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        busy = 1'b0;
        if (start) w_state_next = ST_ARM;
      end
      ST_ARM: w_state_next = ST_RUN;
      ST_RUN: begin
        work = 1'b1;
        if (w_wd_expire) w_state_next = ST_ERR;
        else if (w_dt >= cnt_t'(VECTORS)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_wd_expire) w_state_next = ST_ERR;
        else if (w_quiet_expire) w_state_next = ST_CHECK;
      end
      ST_CHECK: w_state_next = w_next_phase ? ST_ARM : ST_DONE;
      ST_ERR:   w_state_next = ST_DONE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_both       <= 1'b0;
      r_enc        <= 1'b1;
      r_phase      <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_done       <= 1'b0;
      r_base_t     <= '0;
      r_base_c     <= '0;
      r_total_prev <= '0;
      r_run_total  <= '0;
      r_run_errors <= '0;
    end else begin
      r_state      <= w_state_next;
      r_total_prev <= total;
      r_done       <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_both       <= both_modes;
            r_enc        <= enc_first;
            r_phase      <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_run_total  <= '0;
            r_run_errors <= '0;
          end
        end
        ST_ARM: begin
          r_base_t <= total;
          r_base_c <= correct;
        end
        ST_CHECK: begin
          r_run_total  <= w_sum_total;
          r_run_errors <= w_sum_err;
          if (w_next_phase) begin
            r_phase <= 1'b1;
            r_enc   <= ~r_enc;
          end else begin
            r_pass <= (w_sum_err == '0);
          end
        end
        ST_ERR: begin
          r_run_total  <= w_sum_total;
          r_run_errors <= w_sum_err;
          r_timeout    <= 1'b1;
          r_pass       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign enc        = r_enc;
  assign done       = r_done;
  assign pass       = r_pass;
  assign timeout    = r_timeout;
  assign phase      = r_phase;
  assign run_total  = r_run_total;
  assign run_errors = r_run_errors;

endmodule
